// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Multi-cycle MIPS main controller. A Moore FSM sequences the shared
//            ALU and the unified instruction/data memory through fetch,
//            decode, execute, memory and write-back. It traps on illegal
//            opcodes and, optionally, on memory timeouts.
// Config   : `define MULTICYCLE_CTRL_MEM_WAIT_EN to honour mem_ready and add
//            the memory wait-state timeout counter. When it is undefined,
//            mem_ready is treated as always 1.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15    // 1..255 wait cycles before trap
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op_code,
    input  logic       br_taken,
    input  logic       mem_ready,
    output logic       PCWr,
    output logic       IorD,
    output logic       IRWr,
    output logic       MemRd,
    output logic       MemWr,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWr,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       instr_done,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic [3:0] state
);

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_IMMEX  = 4'd9;
    localparam logic [3:0] S_IMMWB  = 4'd10;
    localparam logic [3:0] S_BRANCH = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;
    localparam logic [3:0] S_TRAP   = 4'd13;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    logic [3:0] state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic       is_sw_q, is_sw_d;     // LW/SW choice captured in DECODE
    logic       ready_w;              // effective memory handshake
    logic       timeout_w;            // this wait cycle exhausts the budget

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    logic [7:0] wait_q, wait_d;
    logic       in_wait_state_w;

    assign ready_w         = mem_ready;
    assign in_wait_state_w = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                             (state_q == S_MEMWR);
    // Trap on the MEM_TIMEOUT-th consecutive low-ready cycle of one access
    assign timeout_w       = in_wait_state_w && !mem_ready &&
                             (wait_q == 8'(MEM_TIMEOUT - 1));

    // Wait counter: clears on any state change, counts cycles spent waiting
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = 8'd0;
        end else if (in_wait_state_w && !mem_ready) begin
            wait_d = wait_q + 8'd1;
        end
    end

    // Wait counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= 8'd0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    logic unused_mem_ready;

    assign ready_w          = 1'b1;
    assign timeout_w        = 1'b0;
    assign unused_mem_ready = mem_ready | (MEM_TIMEOUT == 0);
`endif

    // Next-state logic, trap-cause capture and LW/SW latch
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        is_sw_d = is_sw_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH: begin
                if (timeout_w) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else if (ready_w) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                is_sw_d = (op_code == 6'b101011);
                case (op_code)
                    6'b000000:                 state_d = S_EXEC;
                    6'b100011, 6'b101011:      state_d = S_MEMADR;
                    6'b000001, 6'b000100, 6'b000101,
                    6'b000110, 6'b000111:      state_d = S_BRANCH;
                    6'b000010:                 state_d = S_JUMP;
                    6'b001000, 6'b001001, 6'b001010, 6'b001011,
                    6'b001100, 6'b001101, 6'b001110:
                                               state_d = S_IMMEX;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (timeout_w) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else if (ready_w) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR: begin
                if (timeout_w) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else if (ready_w) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_IMMEX:  state_d = S_IMMWB;
            S_IMMWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default: begin
                // Unused encodings are treated as a corrupted opcode path
                state_d = S_TRAP;
                cause_d = CAUSE_ILLEGAL;
            end
        endcase
    end

    // State, trap cause and store flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            cause_q <= CAUSE_NONE;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            is_sw_q <= is_sw_d;
        end
    end

    // Moore output decode; FETCH strobes, BRANCH PCWr and MEMWR done are qualified
    always_comb begin
        PCWr       = 1'b0;
        IorD       = 1'b0;
        IRWr       = 1'b0;
        MemRd      = 1'b0;
        MemWr      = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWr      = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        instr_done = 1'b0;
        trap       = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRd   = 1'b1;
                ALUSrcB = 2'b01;
                IRWr    = ready_w;
                PCWr    = ready_w;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                IorD  = 1'b1;
                MemRd = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg   = 1'b1;
                RegWr      = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                MemWr      = 1'b1;
                instr_done = ready_w;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                RegWr      = 1'b1;
                instr_done = 1'b1;
            end
            S_IMMEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
            end
            S_IMMWB: begin
                RegWr      = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 2'b01;
                PCSrc      = 2'b01;
                PCWr       = br_taken;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                PCSrc      = 2'b10;
                PCWr       = 1'b1;
                instr_done = 1'b1;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign trap_cause = cause_q;
    assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Directed self-checking bench for multicycle_ctrl. Follows the
//            MULTICYCLE_CTRL_MEM_WAIT_EN setting of the design build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_IMMEX  = 4'd9;
    localparam logic [3:0] S_IMMWB  = 4'd10;
    localparam logic [3:0] S_BRANCH = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;
    localparam logic [3:0] S_TRAP   = 4'd13;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op_code;
    logic       br_taken;
    logic       mem_ready;
    logic       PCWr, IorD, IRWr, MemRd, MemWr, MemtoReg, RegDst, RegWr, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       instr_done, trap;
    logic [1:0] trap_cause;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .op_code(op_code), .br_taken(br_taken),
        .mem_ready(mem_ready), .PCWr(PCWr), .IorD(IorD), .IRWr(IRWr),
        .MemRd(MemRd), .MemWr(MemWr), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWr(RegWr), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSrc(PCSrc), .instr_done(instr_done), .trap(trap),
        .trap_cause(trap_cause), .state(state)
    );

    always #5 clk = ~clk;

    // Observed control word, same field order as mk()
    logic [18:0] obs;
    assign obs = {PCWr, IorD, IRWr, MemRd, MemWr, MemtoReg, RegDst, RegWr, ALUSrcA,
                  ALUSrcB, ALUOp, PCSrc, instr_done, trap, trap_cause};

    function automatic logic [18:0] mk(
        input logic pcwr, iord, irwr, memrd, memwr, mtr, rdst, rwr, srca,
        input logic [1:0] srcb, aluop, pcsrc,
        input logic done, trp,
        input logic [1:0] cause);
        return {pcwr, iord, irwr, memrd, memwr, mtr, rdst, rwr, srca,
                srcb, aluop, pcsrc, done, trp, cause};
    endfunction

    task automatic chk(input string tag, input logic [3:0] es, input logic [18:0] eo);
        checks++;
        assert (state === es && obs === eo) else begin
            failures++;
            $error("FAIL %s: state=%0d outs=%b expected state=%0d outs=%b",
                   tag, state, obs, es, eo);
        end
    endtask

    logic [18:0] E_ZERO, E_FETCH, E_FETCH_W, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB;
    logic [18:0] E_MEMWR, E_EXEC, E_ALUWB, E_IMMEX, E_IMMWB, E_BR_T, E_BR_N, E_JUMP;
    logic [18:0] E_TRAP_ILL, E_TRAP_TMO;

    initial begin
        //              pc io ir rd wr mr rd rw sa srcB   aluOp  pcSrc  dn tr cause
        E_ZERO     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
        E_FETCH    = mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00);
        E_FETCH_W  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 0, 2'b00);
        E_DECODE   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0, 0, 2'b00);
        E_MEMADR   = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 2'b00);
        E_MEMRD    = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00);
        E_MEMWB    = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00);
        E_MEMWR    = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00);
        E_EXEC     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0, 0, 2'b00);
        E_ALUWB    = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00);
        E_IMMEX    = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b11, 2'b00, 0, 0, 2'b00);
        E_IMMWB    = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00);
        E_BR_T     = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0, 2'b00);
        E_BR_N     = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 1, 0, 2'b00);
        E_JUMP     = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0, 2'b00);
        E_TRAP_ILL = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 2'b01);
        E_TRAP_TMO = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 2'b10);

        rst = 1'b1; mem_ready = 1'b1; op_code = 6'b000000; br_taken = 1'b0;

        // Reset state, then the first FETCH follows release
        @(negedge clk); chk("reset", S_INIT, E_ZERO);
        rst = 1'b0;

        // R-type: 1,2,7,8
        @(negedge clk); chk("r_fetch", S_FETCH, E_FETCH);
        @(negedge clk); chk("r_decode", S_DECODE, E_DECODE);
        @(negedge clk); chk("r_exec", S_EXEC, E_EXEC);
        @(negedge clk); chk("r_aluwb", S_ALUWB, E_ALUWB);

        // LW, zero wait
        @(negedge clk); chk("lw_fetch", S_FETCH, E_FETCH); op_code = 6'b100011;
        @(negedge clk); chk("lw_decode", S_DECODE, E_DECODE);
        @(negedge clk); chk("lw_memadr", S_MEMADR, E_MEMADR);
        @(negedge clk); chk("lw_memrd", S_MEMRD, E_MEMRD);
        @(negedge clk); chk("lw_memwb", S_MEMWB, E_MEMWB);

        // SW, zero wait
        @(negedge clk); chk("sw_fetch", S_FETCH, E_FETCH); op_code = 6'b101011;
        @(negedge clk); chk("sw_decode", S_DECODE, E_DECODE);
        @(negedge clk); chk("sw_memadr", S_MEMADR, E_MEMADR);
        @(negedge clk); chk("sw_memwr", S_MEMWR, E_MEMWR);

        // Immediate, upper boundary of the immediate range
        @(negedge clk); chk("imm_fetch", S_FETCH, E_FETCH); op_code = 6'b001110;
        @(negedge clk); chk("imm_decode", S_DECODE, E_DECODE);
        @(negedge clk); chk("imm_ex", S_IMMEX, E_IMMEX);
        @(negedge clk); chk("imm_wb", S_IMMWB, E_IMMWB);

        // BEQ taken
        @(negedge clk); chk("beqt_fetch", S_FETCH, E_FETCH); op_code = 6'b000100; br_taken = 1'b1;
        @(negedge clk); chk("beqt_decode", S_DECODE, E_DECODE);
        @(negedge clk); chk("beqt_branch", S_BRANCH, E_BR_T);

        // BEQ not taken
        @(negedge clk); chk("beqn_fetch", S_FETCH, E_FETCH); br_taken = 1'b0;
        @(negedge clk); chk("beqn_decode", S_DECODE, E_DECODE);
        @(negedge clk); chk("beqn_branch", S_BRANCH, E_BR_N);

        // Jump
        @(negedge clk); chk("j_fetch", S_FETCH, E_FETCH); op_code = 6'b000010;
        @(negedge clk); chk("j_decode", S_DECODE, E_DECODE);
        @(negedge clk); chk("j_jump", S_JUMP, E_JUMP);

`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
        // LW with two wait cycles in MEMRD
        @(negedge clk); chk("lww_fetch", S_FETCH, E_FETCH); op_code = 6'b100011;
        @(negedge clk); chk("lww_decode", S_DECODE, E_DECODE);
        @(negedge clk); chk("lww_memadr", S_MEMADR, E_MEMADR); mem_ready = 1'b0;
        @(negedge clk); chk("lww_memrd1", S_MEMRD, E_MEMRD);
        @(negedge clk); chk("lww_memrd2", S_MEMRD, E_MEMRD);
        @(negedge clk); chk("lww_memrd3", S_MEMRD, E_MEMRD); mem_ready = 1'b1;
        @(negedge clk); chk("lww_memwb", S_MEMWB, E_MEMWB); mem_ready = 1'b0;

        // Timeout: 15 waiting FETCH cycles, then TRAP cause 10
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); chk($sformatf("tmo_fetch%0d", i), S_FETCH, E_FETCH_W);
        end
        @(negedge clk); chk("tmo_trap", S_TRAP, E_TRAP_TMO);
        rst = 1'b1; mem_ready = 1'b1; op_code = 6'b000000;
        #1 chk("tmo_reset", S_INIT, E_ZERO);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); chk("r2_fetch", S_FETCH, E_FETCH);
        @(negedge clk); chk("r2_decode", S_DECODE, E_DECODE);
        @(negedge clk); chk("r2_exec", S_EXEC, E_EXEC);
`else
        // mem_ready ignored: FETCH completes in one cycle despite ready low
        mem_ready = 1'b0; op_code = 6'b000000;
        @(negedge clk); chk("nowait_fetch", S_FETCH, E_FETCH); mem_ready = 1'b1;
        @(negedge clk); chk("r2_decode", S_DECODE, E_DECODE);
        @(negedge clk); chk("r2_exec", S_EXEC, E_EXEC);
`endif

        // Asynchronous reset in the middle of EXEC
        #2 rst = 1'b1;
        #1 chk("async_reset", S_INIT, E_ZERO);
        #1 rst = 1'b0;
        @(negedge clk); chk("post_rst_fetch", S_FETCH, E_FETCH); op_code = 6'b001111;

        // Opcode just past the immediate range is illegal
        @(negedge clk); chk("lui_decode", S_DECODE, E_DECODE);
        @(negedge clk); chk("lui_trap", S_TRAP, E_TRAP_ILL);
        rst = 1'b1; #1 chk("lui_reset", S_INIT, E_ZERO);
        @(negedge clk); rst = 1'b0;

        // Illegal 111111: trap sticks while mem_ready toggles
        @(negedge clk); chk("ill_fetch", S_FETCH, E_FETCH); op_code = 6'b111111;
        @(negedge clk); chk("ill_decode", S_DECODE, E_DECODE);
        @(negedge clk); chk("ill_trap", S_TRAP, E_TRAP_ILL);
        for (int i = 0; i < 4; i++) begin
            mem_ready = ~mem_ready;
            @(negedge clk); chk($sformatf("ill_hold%0d", i), S_TRAP, E_TRAP_ILL);
        end
        rst = 1'b1; #1 chk("ill_reset", S_INIT, E_ZERO);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
